req_tracker: RTL and testbench
==============================

Name: req_tracker

Overview:
- Requester-side companion to the fixed-priority MSB-to-LSB arbiter.
- Collects per-lane request events into saturating pending counters and drives the arbiter's `req` vector.
- Consumes the arbiter's combinational `gnt`, one pending request per grant.
- Flags starvation and protocol errors.
- Sits between the request sources and the arbiter instance; `gnt` feeds straight back from the arbiter in the same cycle.

Parameters:
- SIZE, 4, number of lanes; same SIZE as the arbiter.
- CNT_W, 4, pending-counter width per lane; max pending is 2^CNT_W-1.
- STARVE_LIMIT, 16, consecutive waiting cycles at which `starve[i]` asserts; range 1..255.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- push  input  SIZE  per-lane new-request strobe, one event per cycle per lane.
- push_ready  output  SIZE  lane can accept a push; high when count[i] != 2^CNT_W-1.
- req  output  SIZE  request vector to the arbiter; req[i] = (count[i] != 0), combinational from registers.
- gnt  input  SIZE  grant vector from the arbiter, sampled same cycle.
- starve  output  SIZE  lane i has waited >= STARVE_LIMIT cycles.
- gnt_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count[i] = 0, wait[i] = 0, gnt_err = 0.
  - Outputs: req = 0, push_ready = all ones, starve = 0.
  - Reset mid-operation discards all pending requests immediately; no grant is consumed during reset.
- Accept: push_acc[i] = push[i] & push_ready[i]. A push to a full lane is dropped silently and count is unchanged.
- Consume: gnt_acc[i] = gnt[i] & req[i].
- Counter update per lane at posedge:
  - push_acc only: count + 1.
  - gnt_acc only: count - 1.
  - Both in the same cycle: count unchanged, and req stays high.
  - Neither: hold.
- Counter boundaries:
  - Never wraps; the full state is blocked by push_ready, and the empty state cannot be consumed because gnt_acc requires req.
- Latency:
  - push at cycle N gives req high at cycle N+1 (from empty).
  - Grant of the last pending request at cycle N gives req low at cycle N+1.
- Wait counter: 8 bits per lane, saturating at 255.
  - Cleared when req[i] = 0 or gnt_acc[i] = 1.
  - Otherwise increments while req[i] & ~gnt[i].
  - starve[i] = (wait[i] >= STARVE_LIMIT), registered-state based.
- gnt_err: set at posedge when gnt has more than one bit set, or when any gnt[i] & ~req[i]. Once set it stays high until reset.
- Malformed grants: even when gnt_err fires, only lanes with gnt_acc decrement. A multi-hot grant on requesting lanes decrements every granted lane and sets gnt_err.
- No combinational path from push to req. gnt affects state only, never outputs in the same cycle.

Optional Feature:
- Macro: REQ_TRACKER_STARVE_EN.
- Defined: wait counters and the starve logic are built as described.
- Undefined: wait counters are not instantiated and `starve` is tied to 0. STARVE_LIMIT is ignored, and all other behaviour is identical.

Test Plan:
- Reset/idle:
  - Hold rst_n=0 for 3 cycles.
  - Expect req=4'b0000, push_ready=4'b1111, starve=0, gnt_err=0.
  - Assert rst_n=0 asynchronously while count[2]=3; req[2] must drop immediately, before the next clk edge.
- Priority with arbiter in loop (SIZE=4):
  - Push lanes 3 and 0 once each at cycle 0.
  - Cycle 1: req=4'b1001, gnt=4'b1000.
  - Cycle 2: req=4'b0001, gnt=4'b0001.
  - Cycle 3: req=4'b0000.
- Full/saturate (CNT_W=2):
  - Push lane 1 for 5 consecutive cycles with gnt forced 0.
  - count[1] reaches 3 and push_ready[1]=0 after the 3rd accept; 4th and 5th pushes are dropped.
  - Then grant lane 1 for 3 cycles; req[1] falls after the 3rd grant.
- Simultaneous push and grant:
  - With count[0]=1, drive push[0]=1 and gnt[0]=1 in the same cycle.
  - count stays 1 and req[0] stays high.
- Starvation (STARVE_LIMIT=4, macro defined):
  - Keep lane 3 always pending so the arbiter starves lane 0 (pushed once).
  - starve[0] rises on the 4th waiting cycle; starve[0] clears the cycle after lane 0 is granted.
  - With the macro undefined, starve stays 0 throughout.
- Protocol error:
  - Drive gnt=4'b0110 with req=4'b0110; both lanes decrement and gnt_err=1 next cycle.
  - Separately, drive gnt=4'b0100 with req=4'b0000; gnt_err=1 and no count changes.
  - gnt_err stays high until rst_n pulses.

Source files
------------

// File: rtl/req_tracker.sv
// req_tracker: per-lane saturating pending counters that drive an arbiter req vector; REQ_TRACKER_STARVE_EN adds wait counters and starve flags.
// Latency: push->req 1 cycle, last grant->req low 1 cycle; full lanes drop push (push_ready low), gnt only updates state.
module req_tracker #(
  parameter int SIZE         = 4,
  parameter int CNT_W        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] push,
  output logic [SIZE-1:0] push_ready,
  output logic [SIZE-1:0] req,
  input  logic [SIZE-1:0] gnt,
  output logic [SIZE-1:0] starve,
  output logic            gnt_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SIZE-1:0]  VEC_ONE = SIZE'(1);

  logic [CNT_W-1:0] count [SIZE];
  logic [SIZE-1:0]  push_acc;
  logic [SIZE-1:0]  gnt_acc;
  logic             multi_hot;
  logic             stray_gnt;

  always_comb begin
    req        = '0;
    push_ready = '0;
    for (int i = 0; i < SIZE; i++) begin
      req[i]        = (count[i] != '0);
      push_ready[i] = (count[i] != CNT_MAX);
    end
  end

  assign push_acc  = push & push_ready;
  assign gnt_acc   = gnt & req;
  // Clearing the lowest set bit leaves something only if more than one bit was set.
  assign multi_hot = |(gnt & (gnt - VEC_ONE));
  assign stray_gnt = |(gnt & ~req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (push_acc[i] && !gnt_acc[i])
          count[i] <= count[i] + CNT_ONE;
        else if (!push_acc[i] && gnt_acc[i])
          count[i] <= count[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gnt_err <= 1'b0;
    else if (multi_hot || stray_gnt)
      gnt_err <= 1'b1;
  end

`ifdef REQ_TRACKER_STARVE_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] wait_cnt [SIZE];

  // Wait restarts whenever the lane is idle or just got served; saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (!req[i] || gnt_acc[i])
          wait_cnt[i] <= '0;
        else if (!gnt[i] && wait_cnt[i] != 8'hFF)
          wait_cnt[i] <= wait_cnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    starve = '0;
    for (int i = 0; i < SIZE; i++) starve[i] = (wait_cnt[i] >= LIMIT);
  end
`else
  // STARVE_LIMIT is referenced only so both builds share one parameter list.
  assign starve = {SIZE{1'b0}} & {SIZE{STARVE_LIMIT != 0}};
`endif

endmodule

// File: tb/tb_req_tracker.sv
// Bench for req_tracker: directed steps then random pushes/grants against a queue-free counting model.
module tb_req_tracker;

  localparam int SIZE  = 4;
  localparam int CNT_W = 2;
  localparam int LIMIT = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [SIZE-1:0] push;
  logic [SIZE-1:0] push_ready;
  logic [SIZE-1:0] req;
  logic [SIZE-1:0] gnt;
  logic [SIZE-1:0] starve;
  logic            gnt_err;

  int tests = 0;
  int fails = 0;

  // Reference model: pending count and waiting-cycle count per lane, plus sticky error.
  int m_cnt [SIZE];
  int m_wait[SIZE];
  bit m_err;

  req_tracker #(.SIZE(SIZE), .CNT_W(CNT_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_ready(push_ready),
    .req(req), .gnt(gnt), .starve(starve), .gnt_err(gnt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < SIZE; i++) begin
      m_cnt[i]  = 0;
      m_wait[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [SIZE-1:0] exp_req();
    logic [SIZE-1:0] v = '0;
    for (int i = 0; i < SIZE; i++) v[i] = (m_cnt[i] > 0);
    return v;
  endfunction

  function automatic logic [SIZE-1:0] exp_ready();
    logic [SIZE-1:0] v = '0;
    for (int i = 0; i < SIZE; i++) v[i] = (m_cnt[i] < MAXC);
    return v;
  endfunction

  function automatic logic [SIZE-1:0] exp_starve();
    logic [SIZE-1:0] v = '0;
`ifdef REQ_TRACKER_STARVE_EN
    for (int i = 0; i < SIZE; i++) v[i] = (m_wait[i] >= LIMIT);
`endif
    return v;
  endfunction

  function automatic void model_step(input logic [SIZE-1:0] p, input logic [SIZE-1:0] g);
    int ones = 0;
    int n_cnt [SIZE];
    for (int i = 0; i < SIZE; i++) begin
      bit pending = (m_cnt[i] > 0);
      bit taken   = g[i] && pending;
      bit added   = p[i] && (m_cnt[i] < MAXC);
      ones += int'(g[i]);
      if (g[i] && !pending) m_err = 1'b1;
      n_cnt[i] = m_cnt[i] + int'(added) - int'(taken);
      if (!pending || taken) m_wait[i] = 0;
      else if (m_wait[i] < 255) m_wait[i] = m_wait[i] + 1;
    end
    if (ones > 1) m_err = 1'b1;
    for (int i = 0; i < SIZE; i++) m_cnt[i] = n_cnt[i];
  endfunction

  // Fixed-priority arbiter, MSB wins.
  function automatic logic [SIZE-1:0] arb(input logic [SIZE-1:0] r);
    for (int i = SIZE - 1; i >= 0; i--)
      if (r[i]) return SIZE'(1) << i;
    return '0;
  endfunction

  // Called at a negedge: drive, check registered outputs, advance one clock.
  task automatic cycle(input logic [SIZE-1:0] p, input logic [SIZE-1:0] g);
    push = p;
    gnt  = g;
    check("req", 8'(req), 8'(exp_req()));
    check("push_ready", 8'(push_ready), 8'(exp_ready()));
    check("starve", 8'(starve), 8'(exp_starve()));
    check("gnt_err", 8'(gnt_err), 8'(m_err));
    @(posedge clk);
    model_step(p, g);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    push  = '0;
    gnt   = '0;
    model_reset();
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    push  = '0;
    gnt   = '0;
    model_reset();

    // Reset / idle
    repeat (3) @(negedge clk);
    check("rst_req", 8'(req), 8'h0);
    check("rst_ready", 8'(push_ready), 8'hF);
    check("rst_starve", 8'(starve), 8'h0);
    check("rst_err", 8'(gnt_err), 8'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Priority with arbiter in the loop
    cycle(4'b1001, 4'b0000);
    check("prio_c1_req", 8'(req), 8'h9);
    cycle(4'b0000, arb(req));
    check("prio_c2_req", 8'(req), 8'h1);
    cycle(4'b0000, arb(req));
    check("prio_c3_req", 8'(req), 8'h0);

    // Saturation of lane 1
    repeat (5) cycle(4'b0010, 4'b0000);
    check("full_ready", 8'(push_ready), 8'hD);
    check("full_req", 8'(req), 8'h2);
    cycle(4'b0000, 4'b0010);
    cycle(4'b0000, 4'b0010);
    check("drain2_req", 8'(req), 8'h2);
    cycle(4'b0000, 4'b0010);
    check("drain3_req", 8'(req), 8'h0);

    // Simultaneous push and grant
    cycle(4'b0001, 4'b0000);
    cycle(4'b0001, 4'b0001);
    check("simul_req", 8'(req), 8'h1);
    cycle(4'b0000, 4'b0001);
    check("simul_drain", 8'(req), 8'h0);

    // Starvation of lane 0 behind lane 3
    cycle(4'b1001, 4'b0000);
    repeat (8) cycle(4'b1000, arb(req));
    check("starve_hi", 8'(starve[0]),
`ifdef REQ_TRACKER_STARVE_EN
          8'h1);
`else
          8'h0);
`endif
    cycle(4'b0000, arb(req));
    cycle(4'b0000, arb(req));
    check("starve_clr", 8'(starve), 8'h0);
    check("starve_req", 8'(req), 8'h0);

    // Protocol errors
    cycle(4'b0110, 4'b0000);
    check("perr_req", 8'(req), 8'h6);
    cycle(4'b0000, 4'b0110);
    check("perr_multi_err", 8'(gnt_err), 8'h1);
    check("perr_multi_req", 8'(req), 8'h0);
    repeat (2) cycle(4'b0000, 4'b0000);
    check("perr_sticky", 8'(gnt_err), 8'h1);
    do_reset(1);
    check("perr_cleared", 8'(gnt_err), 8'h0);
    cycle(4'b0000, 4'b0100);
    check("perr_stray_err", 8'(gnt_err), 8'h1);
    check("perr_stray_ready", 8'(push_ready), 8'hF);
    do_reset(1);

    // Asynchronous reset with lane 2 holding three requests
    repeat (3) cycle(4'b0100, 4'b0000);
    check("async_pre_req", 8'(req), 8'h4);
    check("async_pre_ready", 8'(push_ready), 8'hB);
    #2 rst_n = 1'b0;
    #1 check("async_req", 8'(req), 8'h0);
    check("async_ready", 8'(push_ready), 8'hF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic, mostly arbiter-driven with occasional malformed grants
    for (int n = 0; n < 400; n++) begin
      logic [SIZE-1:0] p;
      logic [SIZE-1:0] g;
      if (n % 100 == 99) begin
        do_reset(1);
      end else begin
        p = SIZE'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) p = '0;
        g = ($urandom_range(0, 15) == 0) ? SIZE'($urandom_range(0, 15)) : arb(req);
        cycle(p, g);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
